// File: rtl/hazard_ctrl_unit.sv
// Hazard detection and pipeline-freeze control for the 5-stage MIPS pipeline.
// The stall and bubble outputs are combinational; only the freeze FSM and the counters are registered.
module hazard_ctrl_unit #(
  parameter int REG_W   = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             uses_rs_id,
  input  logic             uses_rt_id,
  input  logic             branch_id,
  input  logic [REG_W-1:0] dst_ex,
  input  logic             reg_write_ex,
  input  logic             mem_read_ex,
  input  logic [REG_W-1:0] dst_mem,
  input  logic             mem_read_mem,
  input  logic             mem_req_mem,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             memwb_bubble,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int              CW       = $clog2(MEM_LAT) + 1;
  localparam bit              MULTI    = (MEM_LAT > 1);
  localparam logic [CW-1:0]   CNT_LOAD = MULTI ? CW'(MEM_LAT - 2) : '0;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             freeze;
  logic             ex_rs, ex_rt, mem_rs, mem_rt, ex_hit, mem_hit, stall_id;

  // Register 0 is hard-wired to zero, so it can never carry a dependency.
  assign ex_rs   = uses_rs_id && (rs_id != '0) && (rs_id == dst_ex) && reg_write_ex;
  assign ex_rt   = uses_rt_id && (rt_id != '0) && (rt_id == dst_ex) && reg_write_ex;
  assign mem_rs  = uses_rs_id && (rs_id != '0) && (rs_id == dst_mem) && mem_read_mem;
  assign mem_rt  = uses_rt_id && (rt_id != '0) && (rt_id == dst_mem) && mem_read_mem;
  assign ex_hit  = ex_rs || ex_rt;
  assign mem_hit = mem_rs || mem_rt;

  assign stall_id = (ex_hit && mem_read_ex)
                 || (branch_id && ex_hit && !mem_read_ex)
                 || (branch_id && mem_hit);

  // The request that started the access stays asserted while in WAIT and is ignored there.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freeze  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req_mem && MULTI) begin
          freeze  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        freeze = (cnt_q != '0);
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    mem_busy     = 1'b0;
    if (!rst) begin
      if (freeze) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
        mem_busy     = 1'b1;
      end else if (stall_id) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench: three hazard_ctrl_unit instances (memory latency 1, 3, 4) share one stimulus stream
// and are checked every cycle against a cycle-count reference model.
module tb_hazard_ctrl_unit;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       urs, urt, br;
    logic [4:0] dex;
    logic       rwex, mrex;
    logic [4:0] dmem;
    logic       mrmem, mreq;
  } stim_t;

  typedef struct {
    logic [6:0]  o;
    logic [31:0] c;
  } exp_t;

  // {pc, ifid, idex_w, idex_bubble, exmem, memwb_bubble, mem_busy}
  localparam logic [6:0] O_NORM = 7'b1110100;
  localparam logic [6:0] O_FRZ  = 7'b0000011;
  localparam logic [6:0] O_STL  = 7'b0011100;

  localparam int LAT [3] = '{1, 3, 4};
  localparam int CWS [3] = '{3, 32, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [4:0] rs_id = '0, rt_id = '0, dst_ex = '0, dst_mem = '0;
  logic       uses_rs_id = 0, uses_rt_id = 0, branch_id = 0, reg_write_ex = 0;
  logic       mem_read_ex = 0, mem_read_mem = 0, mem_req_mem = 0;

  logic [6:0]  act_o [3];
  logic [31:0] act_c [3];
  logic [2:0]  cnt0;
  logic [31:0] cnt1;
  logic [7:0]  cnt2;
  logic [6:0]  o0, o1, o2;

  hazard_ctrl_unit #(.REG_W(5), .MEM_LAT(1), .CNT_W(3)) u_l1 (
    .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .uses_rs_id(uses_rs_id),
    .uses_rt_id(uses_rt_id), .branch_id(branch_id), .dst_ex(dst_ex), .reg_write_ex(reg_write_ex),
    .mem_read_ex(mem_read_ex), .dst_mem(dst_mem), .mem_read_mem(mem_read_mem), .mem_req_mem(mem_req_mem),
    .pc_write(o0[6]), .ifid_write(o0[5]), .idex_write(o0[4]), .idex_bubble(o0[3]),
    .exmem_write(o0[2]), .memwb_bubble(o0[1]), .mem_busy(o0[0]), .stall_cnt(cnt0));

  hazard_ctrl_unit #(.REG_W(5), .MEM_LAT(3), .CNT_W(32)) u_l3 (
    .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .uses_rs_id(uses_rs_id),
    .uses_rt_id(uses_rt_id), .branch_id(branch_id), .dst_ex(dst_ex), .reg_write_ex(reg_write_ex),
    .mem_read_ex(mem_read_ex), .dst_mem(dst_mem), .mem_read_mem(mem_read_mem), .mem_req_mem(mem_req_mem),
    .pc_write(o1[6]), .ifid_write(o1[5]), .idex_write(o1[4]), .idex_bubble(o1[3]),
    .exmem_write(o1[2]), .memwb_bubble(o1[1]), .mem_busy(o1[0]), .stall_cnt(cnt1));

  hazard_ctrl_unit #(.REG_W(5), .MEM_LAT(4), .CNT_W(8)) u_l4 (
    .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .uses_rs_id(uses_rs_id),
    .uses_rt_id(uses_rt_id), .branch_id(branch_id), .dst_ex(dst_ex), .reg_write_ex(reg_write_ex),
    .mem_read_ex(mem_read_ex), .dst_mem(dst_mem), .mem_read_mem(mem_read_mem), .mem_req_mem(mem_req_mem),
    .pc_write(o2[6]), .ifid_write(o2[5]), .idex_write(o2[4]), .idex_bubble(o2[3]),
    .exmem_write(o2[2]), .memwb_bubble(o2[1]), .mem_busy(o2[0]), .stall_cnt(cnt2));

  always_comb begin
    act_o[0] = o0; act_o[1] = o1; act_o[2] = o2;
    act_c[0] = {29'd0, cnt0}; act_c[1] = cnt1; act_c[2] = {24'd0, cnt2};
  end

  int total = 0;
  int bad   = 0;

  exp_t q [3][$];
  int   busy_left [3];
  longint cnt_m [3];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Monitor: outputs are presented every cycle, so every queued expectation is consumed at the next falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (q[i].size() > 0) begin
        exp_t e;
        e = q[i].pop_front();
        chk($sformatf("inst%0d outputs", i), {25'd0, act_o[i]}, {25'd0, e.o});
        chk($sformatf("inst%0d stall_cnt", i), act_c[i], e.c);
      end
    end
  end

  function automatic bit hit(input logic [4:0] r, input logic u, input logic [4:0] d, input logic en);
    return u && (r != 5'd0) && (r == d) && en;
  endfunction

  task automatic step(input stim_t s);
    bit ex_hit, mem_hit, stall, frz;
    logic [6:0] o;
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; rs_id = s.rs; rt_id = s.rt; uses_rs_id = s.urs; uses_rt_id = s.urt;
    branch_id = s.br; dst_ex = s.dex; reg_write_ex = s.rwex; mem_read_ex = s.mrex;
    dst_mem = s.dmem; mem_read_mem = s.mrmem; mem_req_mem = s.mreq;
    ex_hit  = hit(s.rs, s.urs, s.dex, s.rwex) || hit(s.rt, s.urt, s.dex, s.rwex);
    mem_hit = hit(s.rs, s.urs, s.dmem, s.mrmem) || hit(s.rt, s.urt, s.dmem, s.mrmem);
    stall   = (ex_hit && s.mrex) || (s.br && ex_hit && !s.mrex) || (s.br && mem_hit);
    for (int i = 0; i < 3; i++) begin
      // busy_left counts the remaining cycles of an access; only its last cycle runs unfrozen.
      frz = (busy_left[i] == 0) ? (s.mreq && LAT[i] > 1) : (busy_left[i] > 1);
      if (s.rst)      o = O_NORM;
      else if (frz)   o = O_FRZ;
      else if (stall) o = O_STL;
      else            o = O_NORM;
      e.o = o;
      e.c = cnt_m[i][31:0];
      q[i].push_back(e);
      if (s.rst) begin
        busy_left[i] = 0;
        cnt_m[i]     = 0;
      end else begin
        if (busy_left[i] == 0) begin
          if (frz) busy_left[i] = LAT[i] - 1;
        end else busy_left[i]--;
        if (!o[6] && cnt_m[i] < ((64'd1 << CWS[i]) - 1)) cnt_m[i]++;
      end
    end
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t load_use();
    stim_t s;
    s = '0;
    s.rs = 5'd3; s.urs = 1; s.dex = 5'd3; s.rwex = 1; s.mrex = 1;
    return s;
  endfunction

  initial begin
    stim_t s;
    for (int i = 0; i < 3; i++) begin busy_left[i] = 0; cnt_m[i] = 0; end
    @(posedge clk);
    s = quiet(); s.rst = 1; step(s); step(s);

    // load-use then bubble
    step(load_use());
    s = quiet(); s.rs = 5'd3; s.urs = 1; step(s);
    @(negedge clk); chk("load-use count", {29'd0, cnt0}, 32'd1);

    // register 0 and unused operands never match
    s = quiet(); s.urs = 1; s.rwex = 1; s.mrex = 1; step(s);
    s = quiet(); s.rt = 5'd7; s.urt = 0; s.dex = 5'd7; s.rwex = 1; s.mrex = 1; step(s);
    @(negedge clk); chk("zero-reg count", {29'd0, cnt0}, 32'd1);

    // branch vs load: two stall cycles
    s = quiet(); s.br = 1; s.rt = 5'd5; s.urt = 1; s.dex = 5'd5; s.rwex = 1; s.mrex = 1; step(s);
    s = quiet(); s.br = 1; s.rt = 5'd5; s.urt = 1; s.dmem = 5'd5; s.mrmem = 1; step(s);
    s = quiet(); s.br = 1; s.rt = 5'd5; s.urt = 1; step(s);
    @(negedge clk); chk("branch-load count", {29'd0, cnt0}, 32'd3);

    // branch vs ALU result
    s = quiet(); s.br = 1; s.rs = 5'd9; s.urs = 1; s.dex = 5'd9; s.rwex = 1; step(s);
    step(quiet()); step(quiet());

    // multi-cycle access with a concurrent load-use condition
    s = load_use(); s.mreq = 1; step(s); step(s);
    @(negedge clk); chk("lat3 busy 2nd cycle", {25'd0, o1}, {25'd0, O_FRZ});
    step(s);
    @(negedge clk); chk("lat3 stall after freeze", {25'd0, o1}, {25'd0, O_STL});
    step(load_use());
    repeat (4) step(quiet());

    // reset on the second frozen cycle, then a fresh freeze
    s = quiet(); s.mreq = 1; step(s);
    s.rst = 1; step(s);
    @(negedge clk); chk("reset forces idle outputs", {25'd0, o2}, {25'd0, O_NORM});
    s.rst = 0; step(s);
    @(negedge clk); chk("post-reset count", {24'd0, cnt2}, 32'd0);
    chk("post-reset fresh freeze", {31'd0, o2[0]}, 32'd1);
    step(s); step(s);
    s.mreq = 0; repeat (3) step(s);

    // saturation of the 3-bit counter
    s = quiet(); s.rst = 1; step(s);
    repeat (10) step(load_use());
    @(negedge clk); chk("saturated count", {29'd0, cnt0}, 32'd7);
    step(quiet());
    @(negedge clk); chk("saturation holds", {29'd0, cnt0}, 32'd7);

    // randomized traffic
    repeat (600) begin
      s.rst   = ($urandom_range(0, 49) == 0);
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.urs   = 1'($urandom_range(0, 1));
      s.urt   = 1'($urandom_range(0, 1));
      s.br    = 1'($urandom_range(0, 1));
      s.dex   = 5'($urandom_range(0, 3));
      s.rwex  = 1'($urandom_range(0, 1));
      s.mrex  = 1'($urandom_range(0, 1));
      s.dmem  = 5'($urandom_range(0, 3));
      s.mrmem = 1'($urandom_range(0, 1));
      s.mreq  = ($urandom_range(0, 3) == 0);
      step(s);
    end

    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("inst%0d queue drained", i), q[i].size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
